// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-response state encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // The response slot is either empty or holds one read result.
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, searching from the requester after the last winner.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic             found;

  // p0: combinational search starting at last_grant+1 and wrapping back to last_grant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (advance && rst_n) begin
      for (int i = 1; i <= N; i++) begin
        cand = IDX_W'((int'(last_grant) + i) % N);
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(N - 1);
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read mux between NUM_REQ requesters and registers the result with a one-hot owner tag.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_select,
  input  logic [WIDTH-1:0]          mux_data,
  output logic                      rsp_valid,
  output logic [NUM_REQ-1:0]        rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  input  logic                      rsp_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // x0 is hardwired to zero regardless of what the mux presents.
  function automatic logic [WIDTH-1:0] x0_override(input logic [ADDR_W-1:0] addr,
                                                   input logic [WIDTH-1:0]  data);
    return (addr == ADDR_W'(REG_ZERO)) ? '0 : data;
  endfunction

  rsp_state_e          state_p1, state_next;
  logic                advance_p0;
  logic                vld_p0;
  logic [NUM_REQ-1:0]  grant_p0;
  logic [IDX_W-1:0]    grant_idx_p0;
  logic [ADDR_W-1:0]   sel_p0;

  assign rsp_valid  = (state_p1 == RSP_FULL);
  assign advance_p0 = !rsp_valid || rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (advance_p0),
    .grant     (grant_p0),
    .grant_idx (grant_idx_p0)
  );

  // p0: grant selects the address that steers the shared read mux
  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_p0[i]) sel_p0 = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign vld_p0     = |grant_p0;
  assign req_ready  = grant_p0;
  assign mux_select = sel_p0;

  always_comb begin
    state_next = state_p1;
    case (state_p1)
      RSP_EMPTY: if (vld_p0) state_next = RSP_FULL;
      RSP_FULL:  if (rsp_ready) state_next = vld_p0 ? RSP_FULL : RSP_EMPTY;
      default:   state_next = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= RSP_EMPTY;
    end else begin
      state_p1 <= state_next;
    end
  end

  // p1: response register; loads on every grant, otherwise holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (vld_p0) begin
      rsp_id   <= grant_p0;
      rsp_data <= x0_override(sel_p0, mux_data);
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a table-driven model of the 32-entry read mux.
module tb_regfile_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         mux_select;
  logic [WIDTH-1:0]          mux_data;
  logic                      rsp_valid;
  logic [NUM_REQ-1:0]        rsp_id;
  logic [WIDTH-1:0]          rsp_data;
  logic                      rsp_ready;

  logic [WIDTH-1:0] regs [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mux_data = regs[mux_select];

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mux_select (mux_select),
    .mux_data   (mux_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[0] = 32'hFFFF_FFFF;
    regs[5] = 32'hDEAD_BEEF;

    // reset held with every requester asking
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_addr  = {5'd3, 5'd2, 5'd1, 5'd5};
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_ready_pre", 32'(req_ready), 32'h0);
      step();
      chk("rst_valid", 32'(rsp_valid), 32'h0);
      chk("rst_data", rsp_data, 32'h0);
      chk("rst_id", 32'(rsp_id), 32'h0);
    end

    // single read from requester 0, address 5
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_addr  = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    chk("rd_select", 32'(mux_select), 32'd5);
    chk("rd_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    chk("rd_valid", 32'(rsp_valid), 32'h1);
    chk("rd_id", 32'(rsp_id), 32'b0001);
    chk("rd_data", rsp_data, 32'hDEAD_BEEF);
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_select", 32'(mux_select), 32'h0);
    step();
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // x0 read from requester 2 while the mux presents all ones
    req_valid = 4'b0100;
    req_addr  = {5'd0, 5'd0, 5'd7, 5'd7};
    #1;
    chk("x0_ready", 32'(req_ready), 32'b0100);
    chk("x0_select", 32'(mux_select), 32'd0);
    step();
    req_valid = 4'b0000;
    chk("x0_valid", 32'(rsp_valid), 32'h1);
    chk("x0_id", 32'(rsp_id), 32'b0100);
    chk("x0_data", rsp_data, 32'h0);

    // reset so requester 0 leads the fairness sweep
    rst_n = 1'b0;
    step();
    chk("rst2_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;

    // fairness: all requesters valid, addresses 8..11
    req_valid = 4'hF;
    req_addr  = {5'd11, 5'd10, 5'd9, 5'd8};
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      chk("rr_select", 32'(mux_select), 32'(8 + k % 4));
      step();
      chk("rr_valid", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(1 << (k % 4)));
      chk("rr_data", rsp_data, 32'h1000_0008 + 32'(k % 4));
    end

    // back-pressure: response from requester 3 pending, requester 1 waiting
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'b1000);
      chk("bp_data", rsp_data, 32'h1000_000B);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    chk("bp_release_select", 32'(mux_select), 32'd9);
    step();
    chk("bp_next_valid", 32'(rsp_valid), 32'h1);
    chk("bp_next_id", 32'(rsp_id), 32'b0010);
    chk("bp_next_data", rsp_data, 32'h1000_0009);

    // reset during a stall drops the pending response and restores requester 0 priority
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rs_ready", 32'(req_ready), 32'h0);
    step();
    chk("rs_valid", 32'(rsp_valid), 32'h0);
    chk("rs_data", rsp_data, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rs_first_ready", 32'(req_ready), 32'b0001);
    step();
    chk("rs_first_id", 32'(rsp_id), 32'b0001);
    chk("rs_first_data", rsp_data, 32'h1000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
